register_file: RTL and testbench



---
 rtl/register_file.sv | 168 ++++++++++++++++
 tb/tb_register_file.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ============================================================================
// register_file : sixteen-bit datapath register bank (AR, DR, PC, IR, R1-R7, AC)
//                 with common write bus, priority read bus and ALU operand taps.
// Revision 1.0
// ============================================================================
`default_nettype none

module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMREAD,
    input  logic        WAR,
    input  logic        WDR,
    input  logic        WPC,
    input  logic        WIR,
    input  logic        WR1,
    input  logic        WR2,
    input  logic        WR3,
    input  logic        WR4,
    input  logic        WR5,
    input  logic        WR6,
    input  logic        WR7,
    input  logic        WAC,
    input  logic        RAR,
    input  logic        RDR,
    input  logic        RPC,
    input  logic        RIR,
    input  logic        RR1,
    input  logic        RR2,
    input  logic        RR3,
    input  logic        RR4,
    input  logic        RR5,
    input  logic        RR6,
    input  logic        RR7,
    input  logic        RAC,
    input  logic        LDALUIR,
    input  logic        LDALUIDX,
    input  logic        LDALUIDY,
    input  logic        LDALUR1,
    input  logic        LDALUR5,
    input  logic        LDALUAC,
    input  logic        RSTR1,
    input  logic        RSTR2,
    input  logic        RSTR3,
    input  logic        RSTR4,
    input  logic        RSTR5,
    input  logic        RSTR6,
    input  logic        RSTR7,
    input  logic        R2INC,
    input  logic        PCINC,
    input  logic [2:0]  ALUMUX,
    input  logic [15:0] INSIN,
    input  logic [15:0] DIN,
    input  logic [15:0] BIN,
    output logic [15:0] DMADDR,
    output logic [15:0] IMADDR,
    output logic [15:0] DOUT,
    output logic [15:0] ACOUT,
    output logic [15:0] ALUOUT,
    output logic [15:0] BOUT,
    output logic [15:0] IROUT
);

    localparam logic [2:0] c_SEL_IR  = 3'b001;
    localparam logic [2:0] c_SEL_IDX = 3'b010;
    localparam logic [2:0] c_SEL_IDY = 3'b011;
    localparam logic [2:0] c_SEL_R1  = 3'b100;
    localparam logic [2:0] c_SEL_R5  = 3'b101;

    logic [15:0] ar_q, ar_d;
    logic [15:0] dr_q, dr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ac_q, ac_d;
    logic [15:0] rn_q [1:7];
    logic [15:0] rn_d [1:7];

    logic [7:1] w_rn_wr;
    logic [7:1] w_rn_clr;
    logic [7:1] w_rn_rd;

    assign w_rn_wr  = {WR7, WR6, WR5, WR4, WR3, WR2, WR1};
    assign w_rn_clr = {RSTR7, RSTR6, RSTR5, RSTR4, RSTR3, RSTR2, RSTR1};
    assign w_rn_rd  = {RR7, RR6, RR5, RR4, RR3, RR2, RR1};

    // Per-register priority: clear, then load, then increment, else hold.
    always_comb begin
        ar_d = ar_q;
        dr_d = dr_q;
        pc_d = pc_q;
        ir_d = ir_q;
        ac_d = ac_q;
        if (WAR)          ar_d = BIN;
        if (MEMREAD)      dr_d = DIN;
        else if (WDR)     dr_d = BIN;
        if (WPC)          pc_d = BIN;
        else if (PCINC)   pc_d = pc_q + 16'd1;
        if (WIR)          ir_d = INSIN;
        if (WAC)          ac_d = BIN;
        for (int n = 1; n <= 7; n++) begin
            rn_d[n] = rn_q[n];
            if (w_rn_clr[n])
                rn_d[n] = 16'h0000;
            else if (w_rn_wr[n])
                rn_d[n] = BIN;
            else if (n == 2 && R2INC)
                rn_d[n] = rn_q[n] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= 16'h0000;
            dr_q <= 16'h0000;
            pc_q <= 16'h0000;
            ir_q <= 16'h0000;
            ac_q <= 16'h0000;
            for (int n = 1; n <= 7; n++)
                rn_q[n] <= 16'h0000;
        end else begin
            ar_q <= ar_d;
            dr_q <= dr_d;
            pc_q <= pc_d;
            ir_q <= ir_d;
            ac_q <= ac_d;
            for (int n = 1; n <= 7; n++)
                rn_q[n] <= rn_d[n];
        end
    end

    assign DMADDR = ar_q;
    assign IMADDR = pc_q;
    assign DOUT   = dr_q;
    assign IROUT  = ir_q;
    assign ACOUT  = LDALUAC ? ac_q : 16'h0000;

    always_comb begin
        BOUT = 16'h0000;
        if      (RAR)        BOUT = ar_q;
        else if (RDR)        BOUT = dr_q;
        else if (RPC)        BOUT = pc_q;
        else if (RIR)        BOUT = ir_q;
        else if (w_rn_rd[1]) BOUT = rn_q[1];
        else if (w_rn_rd[2]) BOUT = rn_q[2];
        else if (w_rn_rd[3]) BOUT = rn_q[3];
        else if (w_rn_rd[4]) BOUT = rn_q[4];
        else if (w_rn_rd[5]) BOUT = rn_q[5];
        else if (w_rn_rd[6]) BOUT = rn_q[6];
        else if (w_rn_rd[7]) BOUT = rn_q[7];
        else if (RAC)        BOUT = ac_q;
    end

    // R3 and R4 double as the IDX and IDY index registers.
    always_comb begin
        ALUOUT = 16'h0000;
        case (ALUMUX)
            c_SEL_IR:  if (LDALUIR)  ALUOUT = ir_q;
            c_SEL_IDX: if (LDALUIDX) ALUOUT = rn_q[3];
            c_SEL_IDY: if (LDALUIDY) ALUOUT = rn_q[4];
            c_SEL_R1:  if (LDALUR1)  ALUOUT = rn_q[1];
            c_SEL_R5:  if (LDALUR5)  ALUOUT = rn_q[5];
            default:   ALUOUT = 16'h0000;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed stimulus with an array-based register model and
//                    a per-cycle compare of every output.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

    // Register index order doubles as BOUT read priority order.
    localparam int c_AR = 0, c_DR = 1, c_PC = 2, c_IR = 3, c_R1 = 4, c_R2 = 5;
    localparam int c_R3 = 6, c_R4 = 7, c_R5 = 8, c_AC = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEMREAD;
    logic [11:0] we;
    logic [11:0] re;
    logic [7:1]  rstr;
    logic        LDALUIR, LDALUIDX, LDALUIDY, LDALUR1, LDALUR5, LDALUAC;
    logic        R2INC, PCINC;
    logic [2:0]  ALUMUX;
    logic [15:0] INSIN, DIN, BIN;
    logic [15:0] DMADDR, IMADDR, DOUT, ACOUT, ALUOUT, BOUT, IROUT;

    int checks = 0;
    int errors = 0;

    logic [15:0] m [12];
    logic        model_valid = 1'b0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst(rst), .MEMREAD(MEMREAD),
        .WAR(we[0]), .WDR(we[1]), .WPC(we[2]), .WIR(we[3]),
        .WR1(we[4]), .WR2(we[5]), .WR3(we[6]), .WR4(we[7]),
        .WR5(we[8]), .WR6(we[9]), .WR7(we[10]), .WAC(we[11]),
        .RAR(re[0]), .RDR(re[1]), .RPC(re[2]), .RIR(re[3]),
        .RR1(re[4]), .RR2(re[5]), .RR3(re[6]), .RR4(re[7]),
        .RR5(re[8]), .RR6(re[9]), .RR7(re[10]), .RAC(re[11]),
        .LDALUIR(LDALUIR), .LDALUIDX(LDALUIDX), .LDALUIDY(LDALUIDY),
        .LDALUR1(LDALUR1), .LDALUR5(LDALUR5), .LDALUAC(LDALUAC),
        .RSTR1(rstr[1]), .RSTR2(rstr[2]), .RSTR3(rstr[3]), .RSTR4(rstr[4]),
        .RSTR5(rstr[5]), .RSTR6(rstr[6]), .RSTR7(rstr[7]),
        .R2INC(R2INC), .PCINC(PCINC), .ALUMUX(ALUMUX),
        .INSIN(INSIN), .DIN(DIN), .BIN(BIN),
        .DMADDR(DMADDR), .IMADDR(IMADDR), .DOUT(DOUT), .ACOUT(ACOUT),
        .ALUOUT(ALUOUT), .BOUT(BOUT), .IROUT(IROUT)
    );

    // Model: each register's next value from the rule list, highest rule first.
    always @(posedge clk) begin
        for (int i = 0; i < 12; i++) begin
            automatic logic [15:0] v = m[i];
            automatic logic clr = (i >= c_R1 && i <= 10) ? rstr[i - 3] : 1'b0;
            automatic logic inc = (i == c_PC) ? PCINC : ((i == c_R2) ? R2INC : 1'b0);
            if (rst)                         v = 16'h0000;
            else if (clr)                    v = 16'h0000;
            else if (i == c_DR && MEMREAD)   v = DIN;
            else if (we[i])                  v = (i == c_IR) ? INSIN : BIN;
            else if (inc)                    v = 16'((32'(m[i]) + 1) % 65536);
            m[i] <= v;
        end
        if (rst) model_valid <= 1'b1;
    end

    function automatic logic [15:0] exp_bout();
        for (int i = 0; i < 12; i++)
            if (re[i]) return m[i];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_alu();
        case (ALUMUX)
            3'd1:    return LDALUIR  ? m[c_IR] : 16'h0000;
            3'd2:    return LDALUIDX ? m[c_R3] : 16'h0000;
            3'd3:    return LDALUIDY ? m[c_R4] : 16'h0000;
            3'd4:    return LDALUR1  ? m[c_R1] : 16'h0000;
            3'd5:    return LDALUR5  ? m[c_R5] : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            cmp("model DMADDR", DMADDR, m[c_AR]);
            cmp("model IMADDR", IMADDR, m[c_PC]);
            cmp("model DOUT",   DOUT,   m[c_DR]);
            cmp("model IROUT",  IROUT,  m[c_IR]);
            cmp("model ACOUT",  ACOUT,  LDALUAC ? m[c_AC] : 16'h0000);
            cmp("model ALUOUT", ALUOUT, exp_alu());
            cmp("model BOUT",   BOUT,   exp_bout());
        end
    end

    task automatic idle();
        rst = 1'b0; MEMREAD = 1'b0; we = '0; re = '0; rstr = '0;
        LDALUIR = 1'b0; LDALUIDX = 1'b0; LDALUIDY = 1'b0;
        LDALUR1 = 1'b0; LDALUR5 = 1'b0; LDALUAC = 1'b0;
        R2INC = 1'b0; PCINC = 1'b0; ALUMUX = 3'd0;
        INSIN = '0; DIN = '0; BIN = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp("reset BOUT", BOUT, 16'h0000);
        cmp("reset IMADDR", IMADDR, 16'h0000);

        BIN = 16'd12; we[c_AC] = 1'b1; tick(); idle();
        re[c_AC] = 1'b1; #1;
        cmp("AC write/read BOUT", BOUT, 16'd12);
        re = '0; LDALUAC = 1'b1; #1;
        cmp("ACOUT strobe high", ACOUT, 16'd12);
        LDALUAC = 1'b0; #1;
        cmp("ACOUT strobe low", ACOUT, 16'd0);

        BIN = 16'd20; we[c_AR] = 1'b1; tick(); idle();
        cmp("DMADDR", DMADDR, 16'd20);

        BIN = 16'd24; we[c_DR] = 1'b1; tick(); idle();
        re[c_DR] = 1'b1; #1;
        cmp("DR BOUT", BOUT, 16'd24);
        cmp("DOUT", DOUT, 16'd24);

        BIN = 16'h1111; we[c_R1] = 1'b1; tick(); idle();
        INSIN = 16'd212; we[c_IR] = 1'b1; tick(); idle();
        LDALUIR = 1'b1; ALUMUX = 3'b001; #1;
        cmp("ALUOUT IR", ALUOUT, 16'd212);
        cmp("IROUT", IROUT, 16'd212);
        tick();
        ALUMUX = 3'b100; LDALUR1 = 1'b0; #1;
        cmp("ALUOUT R1 gated", ALUOUT, 16'd0);
        LDALUR1 = 1'b1; #1;
        cmp("ALUOUT R1", ALUOUT, 16'h1111);
        tick(); idle();

        BIN = 16'd220; we[c_PC] = 1'b1; tick(); idle();
        PCINC = 1'b1; tick(); idle();
        cmp("PC increment", IMADDR, 16'd221);

        BIN = 16'd224; we[c_R2] = 1'b1; tick(); idle();
        R2INC = 1'b1; tick(); idle();
        re[c_R2] = 1'b1; #1;
        cmp("R2 increment", BOUT, 16'd225);
        tick(); idle();

        BIN = 16'h0050; we[c_PC] = 1'b1; PCINC = 1'b1; tick(); idle();
        cmp("PC write beats inc", IMADDR, 16'h0050);

        BIN = 16'hFFFF; we[c_PC] = 1'b1; tick(); idle();
        PCINC = 1'b1; tick(); idle();
        cmp("PC wrap", IMADDR, 16'h0000);

        rstr[2] = 1'b1; tick(); idle();
        re[c_R2] = 1'b1; #1;
        cmp("RSTR2 clears", BOUT, 16'h0000);
        tick(); idle();

        BIN = 16'd9; we[c_R2] = 1'b1; tick(); idle();
        rstr[2] = 1'b1; we[c_R2] = 1'b1; R2INC = 1'b1; BIN = 16'd5; tick(); idle();
        re[c_R2] = 1'b1; #1;
        cmp("clear beats write", BOUT, 16'h0000);
        tick(); idle();

        MEMREAD = 1'b1; DIN = 16'd7; we[c_DR] = 1'b1; BIN = 16'd9; tick(); idle();
        cmp("MEMREAD beats WDR", DOUT, 16'd7);

        for (int i = 0; i < 12; i++) begin
            BIN = 16'h1000 + 16'(i * 16'h0111);
            INSIN = 16'hC000 + 16'(i);
            we[i] = 1'b1;
            tick(); idle();
        end
        for (int i = 0; i < 12; i++) begin
            automatic logic [15:0] e = (i == c_IR) ? 16'hC003 : 16'h1000 + 16'(i * 16'h0111);
            re[i] = 1'b1; #1;
            cmp($sformatf("BOUT reg %0d", i), BOUT, e);
            tick(); idle();
        end

        re[c_AR] = 1'b1; re[c_AC] = 1'b1; #1;
        cmp("BOUT priority AR", BOUT, 16'h1000);
        re = '0; #1;
        cmp("BOUT none", BOUT, 16'h0000);
        tick();

        ALUMUX = 3'd2; LDALUIDX = 1'b1; #1;
        cmp("ALUOUT IDX", ALUOUT, 16'h1666);
        ALUMUX = 3'd3; LDALUIDY = 1'b1; #1;
        cmp("ALUOUT IDY", ALUOUT, 16'h1777);
        tick(); idle();

        rst = 1'b1; we = '1; BIN = 16'hBEEF; PCINC = 1'b1; R2INC = 1'b1; tick(); idle();
        re[c_AC] = 1'b1; LDALUAC = 1'b1; LDALUR5 = 1'b1; ALUMUX = 3'd5; #1;
        cmp("rst beats WAC", BOUT, 16'h0000);
        cmp("rst ACOUT", ACOUT, 16'h0000);
        cmp("rst ALUOUT", ALUOUT, 16'h0000);
        cmp("rst DMADDR", DMADDR, 16'h0000);
        cmp("rst IMADDR", IMADDR, 16'h0000);
        cmp("rst IROUT", IROUT, 16'h0000);
        tick(); idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
